// File: rtl/mips32_pkg.sv
// Shared types and constants for the mips32 unified-memory arbiter.
package mips32_pkg;

  localparam int unsigned AW_DEF = 10;
  localparam int unsigned DW_DEF = 32;

  // Requester ids as latched for the access in flight
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Bits needed to hold values 0..max_val
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mips32_starve_cnt.sv
// Saturating count of data grants taken while a fetch was waiting.
module mips32_starve_cnt
  import mips32_pkg::*;
#(
  parameter int unsigned MAX = 3,
  parameter int unsigned CW  = cnt_width(MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          at_max
);

  assign at_max = (cnt == CW'(MAX));

  // clear wins over increment; hold once saturated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Arbitrates the single-port unified memory between fetch and load/store.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned LW = 3;
  localparam int unsigned SW = cnt_width(STARVE_MAX);

  arb_state_e    state, state_nx;
  logic          win_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [LW-1:0] lat_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;
  logic [SW-1:0] starve_cnt;
  logic          starve_max_c;
  logic          starve_inc_c;
  logic          starve_clr_c;
  logic          in_range_c;
  logic          issue_done_c;
  logic          load_done_c;
  logic          resp_c;
  logic [DW-1:0] resp_data_c;
  logic          if_wait;
  logic          dm_wait;

  assign in_range_c  = (32'(addr_q) < DEPTH);
  assign resp_c      = issue_done_c | load_done_c;
  assign resp_data_c = load_done_c ? mem_rdata : '0;

  // Response routing: live value on the pulse, last captured value otherwise
  assign if_rvalid = resp_c && (win_q == REQ_IF);
  assign dm_rvalid = resp_c && (win_q == REQ_DM);
  assign dm_err    = dm_rvalid && !in_range_c;
  assign if_rdata  = if_rvalid ? resp_data_c : if_rdata_q;
  assign dm_rdata  = dm_rvalid ? resp_data_c : dm_rdata_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, grants and memory strobes
  always_comb begin
    state_nx     = state;
    if_gnt       = 1'b0;
    dm_gnt       = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    issue_done_c = 1'b0;
    load_done_c  = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (if_req && (starve_max_c || !dm_req)) begin
            if_gnt   = 1'b1;
            state_nx = ISSUE;
          end else if (dm_req) begin
            dm_gnt   = 1'b1;
            state_nx = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (in_range_c) begin
          mem_en    = 1'b1;
          mem_we    = we_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
        end
        if (we_q || !in_range_c) begin
          issue_done_c = 1'b1;
          state_nx     = IDLE;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == LW'(1)) begin
          load_done_c = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Latch the winning request, run the read-latency counter, hold read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q      <= REQ_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (if_gnt || dm_gnt) begin
        win_q   <= dm_gnt ? REQ_DM : REQ_IF;
        we_q    <= dm_gnt && dm_we;
        addr_q  <= dm_gnt ? dm_addr : if_addr;
        wdata_q <= (dm_gnt && dm_we) ? dm_wdata : '0;
      end
      if (state == ISSUE) begin
        lat_q <= LW'(RD_LAT);
      end else if (state == WAIT) begin
        lat_q <= lat_q - LW'(1);
      end
      if (if_rvalid) begin
        if_rdata_q <= if_rdata;
      end
      if (dm_rvalid) begin
        dm_rdata_q <= dm_rdata;
      end
    end
  end

  // Fetch is forced through after STARVE_MAX data grants in a row
  assign starve_inc_c = dm_gnt && if_req;
  assign starve_clr_c = if_gnt || ((state == IDLE) && !if_req);

  mips32_starve_cnt #(
    .MAX (STARVE_MAX),
    .CW  (SW)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (starve_inc_c),
    .clr    (starve_clr_c),
    .cnt    (starve_cnt),
    .at_max (starve_max_c)
  );

  // Requests must stay asserted until granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_wait <= 1'b0;
      dm_wait <= 1'b0;
    end else begin
      assert (!if_wait || if_req);
      assert (!dm_wait || dm_req);
      if_wait <= if_req && !if_gnt;
      dm_wait <= dm_req && !dm_gnt;
    end
  end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter with RD_LAT=1 and RD_LAT=3 instances.
module tb_mips32_mem_arbiter;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt, dm_rvalid, dm_err;
  logic [DW-1:0] dm_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          b_rst = 1'b1;
  logic          b_if_req = 1'b0;
  logic [AW-1:0] b_if_addr = '0;
  logic          b_if_gnt, b_if_rvalid;
  logic [DW-1:0] b_if_rdata;
  logic          b_dm_gnt, b_dm_rvalid, b_dm_err;
  logic [DW-1:0] b_dm_rdata;
  logic          b_mem_en, b_mem_we;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata;
  logic [DW-1:0] b_mem_rdata;

  logic [DW-1:0] mem1 [2048];
  logic [DW-1:0] mem3 [2048];
  logic [DW-1:0] p0, p1;

  int n_vec = 0;
  int n_err = 0;
  logic exp_dm [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  mips32_mem_arbiter #(
    .AW(AW), .DW(DW), .DEPTH(1024), .RD_LAT(1), .STARVE_MAX(3)
  ) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mips32_mem_arbiter #(
    .AW(AW), .DW(DW), .DEPTH(1024), .RD_LAT(3), .STARVE_MAX(3)
  ) u_dut3 (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(11'd0), .dm_wdata(32'd0),
    .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata), .dm_err(b_dm_err),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 5) return 32'h2000_0028;
    if (i == 7) return 32'h8C08_0004;
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  // Latency-1 memory; contents reloaded while rst is high
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2048; i++) mem1[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) mem1[mem_addr] <= mem_wdata;
      else        mem_rdata      <= mem1[mem_addr];
    end
  end

  // Latency-3 read-only memory
  always @(posedge clk) begin
    if (b_rst) begin
      for (int i = 0; i < 2048; i++) mem3[i] <= init_word(i);
    end
    p0          <= mem3[b_mem_addr];
    p1          <= p0;
    b_mem_rdata <= p1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  g;
    logic drop_if, drop_dm;

    // reset: everything quiet, even with a request present
    repeat (2) @(posedge clk);
    #1;
    dm_req = 1'b1;
    #1;
    check("rst_dm_gnt", 32'(dm_gnt), 32'd0);
    check("rst_ctrl", 32'({if_gnt, if_rvalid, dm_rvalid, dm_err, mem_en, mem_we}), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    dm_req = 1'b0;
    step();
    rst   = 1'b0;
    b_rst = 1'b0;
    step();

    // fetch from word 5
    if_req = 1'b1; if_addr = 11'd5;
    #1;
    check("f_if_gnt", 32'(if_gnt), 32'd1);
    check("f_dm_gnt", 32'(dm_gnt), 32'd0);
    step();
    if_req = 1'b0;
    #1;
    check("f_mem_en", 32'({mem_en, mem_we}), 32'b10);
    check("f_mem_addr", 32'(mem_addr), 32'd5);
    check("f_rvalid_early", 32'(if_rvalid), 32'd0);
    step(); #1;
    check("f_rvalid", 32'(if_rvalid), 32'd1);
    check("f_rdata", if_rdata, 32'h2000_0028);
    step(); #1;
    check("f_rvalid_off", 32'(if_rvalid), 32'd0);
    check("f_rdata_hold", if_rdata, 32'h2000_0028);

    // store 0x11 to word 9, then load it back
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 11'd9; dm_wdata = 32'h11;
    #1;
    check("st_gnt", 32'(dm_gnt), 32'd1);
    step();
    dm_req = 1'b0;
    #1;
    check("st_mem", 32'({mem_en, mem_we}), 32'b11);
    check("st_mem_addr", 32'(mem_addr), 32'd9);
    check("st_mem_wdata", mem_wdata, 32'h11);
    check("st_ack", 32'({dm_rvalid, dm_err}), 32'b10);
    check("st_rdata", dm_rdata, 32'd0);
    step();
    dm_req = 1'b1; dm_we = 1'b0; dm_wdata = 32'd0;
    #1;
    check("ld_gnt", 32'(dm_gnt), 32'd1);
    step();
    dm_req = 1'b0;
    #1;
    check("ld_mem", 32'({mem_en, mem_we}), 32'b10);
    check("ld_rvalid_early", 32'(dm_rvalid), 32'd0);
    step(); #1;
    check("ld_rvalid", 32'(dm_rvalid), 32'd1);
    check("ld_rdata", dm_rdata, 32'h11);
    step();

    // both requesters held: fetch forced through every fourth grant
    if_req = 1'b1; if_addr = 11'd5;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 11'd9;
    g = 0; drop_if = 1'b0; drop_dm = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      #1;
      check("gnt_excl", 32'(if_gnt & dm_gnt), 32'd0);
      if (if_gnt || dm_gnt) begin
        if (g < 8) check($sformatf("arb_order%0d", g), 32'(dm_gnt), 32'(exp_dm[g]));
        else begin drop_if = if_gnt; drop_dm = dm_gnt; end
        g++;
      end
      step();
      if (drop_if) if_req = 1'b0;
      if (drop_dm) dm_req = 1'b0;
      drop_if = 1'b0; drop_dm = 1'b0;
      if (!if_req && !dm_req) break;
    end
    check("arb_total", 32'(g), 32'd10);
    check("arb_drained", 32'({if_req, dm_req}), 32'd0);
    step(); #1;
    check("arb_last_fetch", 32'(if_rvalid), 32'd1);
    check("arb_last_data", if_rdata, 32'h2000_0028);
    step(); step();

    // out-of-range load
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 11'd1024;
    #1;
    check("oor_gnt", 32'(dm_gnt), 32'd1);
    step();
    dm_req = 1'b0;
    #1;
    check("oor_mem_en", 32'(mem_en), 32'd0);
    check("oor_ack", 32'({dm_rvalid, dm_err}), 32'b11);
    check("oor_rdata", dm_rdata, 32'd0);
    step(); #1;
    check("oor_ack_off", 32'({dm_rvalid, dm_err}), 32'b00);

    // idle bus
    for (int i = 0; i < 10; i++) begin
      step(); #1;
      check("idle_ctrl", 32'({mem_en, if_gnt, dm_gnt, if_rvalid, dm_rvalid}), 32'd0);
      check("idle_starve", 32'(u_dut.starve_cnt), 32'd0);
    end

    // RD_LAT=3: reset hits mid-WAIT, the access is dropped, then a clean refetch
    step();
    b_if_req = 1'b1; b_if_addr = 11'd7;
    #1;
    check("b_gnt", 32'(b_if_gnt), 32'd1);
    step();
    b_if_req = 1'b0;
    #1;
    check("b_mem_en", 32'(b_mem_en), 32'd1);
    check("b_mem_addr", 32'(b_mem_addr), 32'd7);
    step(); #1;
    b_rst = 1'b1;
    #1;
    check("b_rst_ctrl", 32'({b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_dm_err, b_mem_en, b_mem_we}), 32'd0);
    check("b_rst_addr", 32'(b_mem_addr), 32'd0);
    check("b_rst_data", b_if_rdata | b_dm_rdata | b_mem_wdata, 32'd0);
    step();
    #3;
    b_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      check("b_no_rvalid", 32'(b_if_rvalid), 32'd0);
    end
    b_if_req = 1'b1; b_if_addr = 11'd7;
    #1;
    check("b_regnt", 32'(b_if_gnt), 32'd1);
    step();
    b_if_req = 1'b0;
    #1;
    check("b_wait1", 32'(b_if_rvalid), 32'd0);
    step(); #1;
    check("b_wait2", 32'(b_if_rvalid), 32'd0);
    step(); #1;
    check("b_wait3", 32'(b_if_rvalid), 32'd0);
    step(); #1;
    check("b_rvalid", 32'(b_if_rvalid), 32'd1);
    check("b_rdata", b_if_rdata, 32'h8C08_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
